// File: rtl/ldpc_pkg.sv
// Shared LDPC message definitions: magnitude width, VNU/CNU message types and field positions.
package ldpc_pkg;

  localparam int MAG_W    = 4;
  localparam int HD_BIT   = MAG_W + 1;
  localparam int SIGN_BIT = MAG_W;
  localparam int MAG_MSB  = MAG_W - 1;
  localparam int MAG_LSB  = 0;

  typedef logic [MAG_W+1:0] vnu_msg_t;
  typedef logic [MAG_W:0]   cnu_msg_t;

endpackage

// File: rtl/cnu_min_finder.sv
// Combinational pairwise-tree search for the two smallest magnitudes and the index of the smallest.
// On a tie the lower index wins, so duplicated minima yield min2 == min1.
module cnu_min_finder import ldpc_pkg::*; #(
  parameter int DEG   = 6,
  parameter int MAG_W = ldpc_pkg::MAG_W
) (
  input  logic [MAG_W-1:0]         mag [0:DEG-1],
  output logic [MAG_W-1:0]         min1,
  output logic [MAG_W-1:0]         min2,
  output logic [$clog2(DEG)-1:0]   idx
);

  localparam int IDX_W = $clog2(DEG);
  localparam int N     = 1 << IDX_W;

  logic [MAG_W-1:0] t1_next [0:N-1];
  logic [MAG_W-1:0] t2_next [0:N-1];
  logic [IDX_W-1:0] ti_next [0:N-1];

  // Padding leaves hold the maximum magnitude and sit right of every real leaf,
  // so the left-preferring merge never selects them over a real input.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      t1_next[i] = (i < DEG) ? mag[i] : '1;
      t2_next[i] = '1;
      ti_next[i] = IDX_W'(i);
    end
    for (int lv = 0; lv < IDX_W; lv++) begin
      for (int k = 0; k < (N >> (lv + 1)); k++) begin
        if (t1_next[2*k+1] < t1_next[2*k]) begin
          t2_next[k] = (t1_next[2*k] < t2_next[2*k+1]) ? t1_next[2*k] : t2_next[2*k+1];
          t1_next[k] = t1_next[2*k+1];
          ti_next[k] = ti_next[2*k+1];
        end else begin
          t2_next[k] = (t2_next[2*k] < t1_next[2*k+1]) ? t2_next[2*k] : t1_next[2*k+1];
          t1_next[k] = t1_next[2*k];
          ti_next[k] = ti_next[2*k];
        end
      end
    end
  end

  assign min1 = t1_next[0];
  assign min2 = t2_next[0];
  assign idx  = ti_next[0];

endmodule

// File: rtl/cnu_minsum.sv
// Two-stage min-sum check node unit with hard-decision parity flag.
// Define CNU_OFFSET_EN to build the offset min-sum variant (magnitudes reduced by OFFSET, clamped at 0).
module cnu_minsum import ldpc_pkg::*; #(
  parameter int DEG    = 6,
  parameter int MAG_W  = ldpc_pkg::MAG_W,
  parameter int OFFSET = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [MAG_W+1:0] Y_in [0:DEG-1],
  output logic             out_valid,
  output logic [MAG_W:0]   X_out [0:DEG-1],
  output logic             parity_ok
);

  localparam int IDX_W = $clog2(DEG);

`ifdef CNU_OFFSET_EN
  localparam bit OFFSET_ON = 1'b1;
`else
  localparam bit OFFSET_ON = 1'b0;
`endif
  localparam int EFF_OFFSET = OFFSET_ON ? OFFSET : 0;

  logic [DEG-1:0]   sign_in, hd_in;
  logic [MAG_W-1:0] mag_in  [0:DEG-1];
  logic [DEG-1:0]   sign_reg, hd_reg;
  logic [MAG_W-1:0] mag_reg [0:DEG-1];
  logic             s1_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEG; gi++) begin : g_split
      assign hd_in[gi]   = Y_in[gi][MAG_W+1];
      assign sign_in[gi] = Y_in[gi][MAG_W];
      assign mag_in[gi]  = Y_in[gi][MAG_W-1:0];
    end
  endgenerate

  // Data is captured regardless of in_valid; only the valid bit carries meaning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_reg     <= '0;
      hd_reg       <= '0;
      s1_valid_reg <= 1'b0;
      for (int i = 0; i < DEG; i++) mag_reg[i] <= '0;
    end else if (en) begin
      sign_reg     <= sign_in;
      hd_reg       <= hd_in;
      s1_valid_reg <= in_valid;
      for (int i = 0; i < DEG; i++) mag_reg[i] <= mag_in[i];
    end
  end

  logic [MAG_W-1:0] min1, min2, min1_adj, min2_adj;
  logic [IDX_W-1:0] idx;
  logic             tsign, hpar;

  cnu_min_finder #(.DEG(DEG), .MAG_W(MAG_W)) u_min_finder (
    .mag  (mag_reg),
    .min1 (min1),
    .min2 (min2),
    .idx  (idx)
  );

  // EFF_OFFSET is 0 in the plain build, which makes these a pass-through.
  assign min1_adj = (int'(min1) > EFF_OFFSET) ? MAG_W'(int'(min1) - EFF_OFFSET) : '0;
  assign min2_adj = (int'(min2) > EFF_OFFSET) ? MAG_W'(int'(min2) - EFF_OFFSET) : '0;
  assign tsign    = ^sign_reg;
  assign hpar     = ^hd_reg;

  logic [MAG_W:0] x_next [0:DEG-1];

  always_comb begin
    for (int i = 0; i < DEG; i++) begin
      x_next[i] = {tsign ^ sign_reg[i], (idx == IDX_W'(i)) ? min2_adj : min1_adj};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      parity_ok <= 1'b0;
      for (int i = 0; i < DEG; i++) X_out[i] <= '0;
    end else if (en) begin
      out_valid <= s1_valid_reg;
      parity_ok <= ~hpar;
      for (int i = 0; i < DEG; i++) X_out[i] <= x_next[i];
    end
  end

endmodule

// File: tb/tb_cnu_minsum.sv
// Self-checking bench for cnu_minsum: directed and random vectors against an exclusion-min reference model.
module tb_cnu_minsum;

  localparam int DEG    = 6;
  localparam int MAG_W  = 4;
  localparam int OFFSET = 1;
  localparam int MAXM   = (1 << MAG_W) - 1;

  typedef logic [DEG-1:0][MAG_W+1:0] vec_t;
  typedef logic [DEG-1:0][MAG_W:0]   xvec_t;
  typedef struct packed {
    logic  v;
    xvec_t x;
    logic  par;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n, en, in_valid;
  logic [MAG_W+1:0] y_in  [0:DEG-1];
  logic             out_valid, parity_ok;
  logic [MAG_W:0]   x_out [0:DEG-1];
  vec_t             y_pk;
  xvec_t            x_pk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_txn  = 0;
  exp_t hist[$];

  cnu_minsum #(.DEG(DEG), .MAG_W(MAG_W), .OFFSET(OFFSET)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .Y_in      (y_in),
    .out_valid (out_valid),
    .X_out     (x_out),
    .parity_ok (parity_ok)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < DEG; i++) begin
      y_in[i] = y_pk[i];
      x_pk[i] = x_out[i];
    end
  end

  // Each output is the min magnitude and XOR of signs over all OTHER inputs.
  function automatic exp_t model(input logic v, input vec_t vec);
    exp_t e;
    int   m;
    logic s;
    e.v   = v;
    e.par = 1'b1;
    for (int i = 0; i < DEG; i++) e.par = e.par ^ vec[i][MAG_W+1];
    for (int i = 0; i < DEG; i++) begin
      m = MAXM + 1;
      s = 1'b0;
      for (int j = 0; j < DEG; j++) begin
        if (j != i) begin
          if (int'(vec[j][MAG_W-1:0]) < m) m = int'(vec[j][MAG_W-1:0]);
          s = s ^ vec[j][MAG_W];
        end
      end
`ifdef CNU_OFFSET_EN
      m = (m > OFFSET) ? m - OFFSET : 0;
`endif
      e.x[i] = {s, MAG_W'(m)};
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [DEG-1:0][MAG_W-1:0] mags,
                              input logic [DEG-1:0] sg, input logic [DEG-1:0] hd);
    vec_t v;
    for (int i = 0; i < DEG; i++) v[i] = {hd[i], sg[i], mags[i]};
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < DEG; i++) v[i] = (MAG_W+2)'($urandom_range(0, (1 << (MAG_W+2)) - 1));
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The output register reflects the entry captured one advancing edge before the newest.
  task automatic compare(input string tag);
    exp_t e;
    if (hist.size() >= 2) e = hist[hist.size()-2];
    else                  e = '0;
    check({tag, "/out_valid"}, 64'(out_valid), 64'(e.v));
    check({tag, "/X_out"},     64'(x_pk),      64'(e.x));
    check({tag, "/parity_ok"}, 64'(parity_ok), 64'(e.par));
    n_txn++;
    $display("txn %0d %s: in_valid=%b en=%b out_valid=%b X_out=%h parity_ok=%b",
             n_txn, tag, in_valid, en, out_valid, x_pk, parity_ok);
  endtask

  task automatic adv(input string tag, input logic v, input vec_t vec);
    @(negedge clk);
    en       = 1'b1;
    in_valid = v;
    y_pk     = vec;
    @(posedge clk);
    hist.push_back(model(v, vec));
    #1;
    compare(tag);
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk);
      en       = 1'b0;
      in_valid = 1'b1;
      y_pk     = rand_vec();
      @(posedge clk);
      #1;
      compare("stall");
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    y_pk     = '0;
    hist.push_back(model(1'b0, '0));
    #3;
    compare("reset");
    @(negedge clk);
    rst_n = 1'b1;

    adv("basic",     1'b1, mk({4'd12, 4'd9, 4'd3, 4'd7, 4'd2, 4'd5}, 6'b011001, 6'b011001));
    adv("ties",      1'b1, mk({4'd6, 4'd15, 4'd8, 4'd1, 4'd1, 4'd4}, 6'b000000, 6'b000000));
    adv("zeros",     1'b1, mk('0, 6'b101010, 6'b000011));
    adv("all_max",   1'b1, mk({DEG{4'd15}}, 6'b111111, 6'b000001));
    adv("off_sat",   1'b1, mk({4'd11, 4'd9, 4'd7, 4'd5, 4'd3, 4'd0}, 6'b100110, 6'b010101));
    adv("last_min",  1'b1, mk({4'd2, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9}, 6'b000001, 6'b111111));

    for (int k = 0; k < 4; k++) adv("b2b", 1'b1, rand_vec());
    stall(3);
    for (int k = 0; k < 4; k++) adv("b2b", 1'b1, rand_vec());

    adv("gap", 1'b1, rand_vec());
    adv("gap", 1'b0, rand_vec());
    adv("gap", 1'b1, rand_vec());
    adv("gap", 1'b0, rand_vec());
    adv("gap", 1'b0, rand_vec());

    adv("pre_rst", 1'b1, rand_vec());
    adv("pre_rst", 1'b1, rand_vec());
    #2;
    rst_n = 1'b0;
    hist.delete();
    hist.push_back(model(1'b0, '0));
    #1;
    compare("async_reset");
    @(negedge clk);
    en       = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    compare("in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    adv("post_rst", 1'b1, rand_vec());
    adv("post_rst", 1'b0, rand_vec());
    for (int k = 0; k < 10; k++) adv("rand", 1'($urandom_range(0, 1)), rand_vec());
    adv("drain", 1'b0, rand_vec());
    adv("drain", 1'b0, rand_vec());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
